// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit width, flit type encoding and type-field helper
package noc_pkg;

  localparam int FW = 40;

  typedef logic [1:0] typ_t;

  localparam typ_t TYP_HEAD = 2'b11;
  localparam typ_t TYP_BODY = 2'b10;
  localparam typ_t TYP_TAIL = 2'b01;
  localparam typ_t TYP_NONE = 2'b00;

  function automatic typ_t flit_typ(input logic [FW-1:0] flit);
    return flit[FW-1:FW-2];
  endfunction

endpackage

// File: rtl/flit_mem.sv
// rtl/flit_mem.sv - DEPTH x FW register array, synchronous write, asynchronous read
module flit_mem #(
  parameter int FW    = 40,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [FW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [FW-1:0] rdata
);

  logic [FW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/input_flit_buffer.sv
// rtl/input_flit_buffer.sv - per-input-port flit FIFO with packet counting for SA
module input_flit_buffer
  import noc_pkg::*;
#(
  parameter int FW    = noc_pkg::FW,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [FW-1:0] flit_in,
  input  logic          w_en,
  input  logic          read,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [1:0]    front_typ,
  output logic [FW-1:0] flit_out,
  output logic          out_vld,
  output logic [AW:0]   pkt_cnt,
  output logic          pkt_rdy,
  output logic          err_ovf,
  output logic          err_udf,
  output logic          err_typ
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] rd_data;
  typ_t          in_typ;
  typ_t          head_typ;
  logic          typ_ok;
  logic          rd_acc;
  logic          wr_acc;
  logic          tail_in;
  logic          tail_out;

  flit_mem #(.FW(FW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (flit_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pkt_rdy = (pkt_cnt != '0);

  assign in_typ   = flit_typ(flit_in);
  assign head_typ = flit_typ(rd_data);
  assign typ_ok   = (in_typ != TYP_NONE);

  // A full buffer still takes a write when the same cycle frees a slot.
  assign rd_acc = read && !empty;
  assign wr_acc = w_en && typ_ok && (!full || rd_acc);

  assign tail_in  = wr_acc && (in_typ == TYP_TAIL);
  assign tail_out = rd_acc && (head_typ == TYP_TAIL);

  assign front_typ = empty ? TYP_NONE : head_typ;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pkt_cnt  <= '0;
      flit_out <= '0;
      out_vld  <= 1'b0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
      err_typ  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + AW'(1);
        flit_out <= rd_data;
      end
      out_vld <= rd_acc;

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      case ({tail_in, tail_out})
        2'b10:   pkt_cnt <= pkt_cnt + (AW+1)'(1);
        2'b01:   pkt_cnt <= pkt_cnt - (AW+1)'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase

      err_ovf <= w_en && typ_ok && full && !rd_acc;
      err_udf <= read && empty;
      err_typ <= w_en && !typ_ok;
    end
  end

endmodule

// File: tb/tb_input_flit_buffer.sv
// tb/tb_input_flit_buffer.sv - scoreboard bench for input_flit_buffer
module tb_input_flit_buffer;
  import noc_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] flit_in = '0;
  logic          w_en = 1'b0;
  logic          read = 1'b0;
  logic          full, empty, out_vld, pkt_rdy, err_ovf, err_udf, err_typ;
  logic [AW:0]   count, pkt_cnt;
  logic [1:0]    front_typ;
  logic [FW-1:0] flit_out;

  input_flit_buffer #(.FW(FW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flit_in   (flit_in),
    .w_en      (w_en),
    .read      (read),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .front_typ (front_typ),
    .flit_out  (flit_out),
    .out_vld   (out_vld),
    .pkt_cnt   (pkt_cnt),
    .pkt_rdy   (pkt_rdy),
    .err_ovf   (err_ovf),
    .err_udf   (err_udf),
    .err_typ   (err_typ)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [FW-1:0] model_q [$];
  logic [FW-1:0] exp_q   [$];

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int id);
    return {t, 38'(id)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Issue one cycle of stimulus; the reference FIFO decides what should come out.
  task automatic step(input logic w, input logic r, input logic [FW-1:0] f, input logic rs);
    logic full_m, rd_m, wr_m;
    w_en = w; read = r; flit_in = f; rst = rs;
    full_m = (model_q.size() == DEPTH);
    rd_m   = r && (model_q.size() != 0);
    wr_m   = w && (f[FW-1:FW-2] != 2'b00) && (!full_m || rd_m);
    @(posedge clk);
    if (rs) model_q.delete();
    else begin
      if (rd_m) exp_q.push_back(model_q.pop_front());
      if (wr_m) model_q.push_back(f);
    end
    #1;
    w_en = 1'b0; read = 1'b0; rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_out: got %0h with no flit expected", flit_out);
      end else begin
        chk("flit_out_order", flit_out, exp_q.pop_front());
      end
    end
  end

  localparam logic [1:0] T5 [10] = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b01,
                                      2'b11, 2'b01, 2'b11, 2'b10, 2'b01};
  localparam int P5 [11] = '{0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0};

  initial begin
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_flit_out", flit_out, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_front_typ", front_typ, 0);
    chk("rst_errs", {err_ovf, err_udf, err_typ}, 0);

    // 1: one full packet
    step(1, 0, mk(TYP_HEAD, 1), 0);
    step(1, 0, mk(TYP_BODY, 2), 0);
    step(1, 0, mk(TYP_BODY, 3), 0);
    step(1, 0, mk(TYP_TAIL, 4), 0);
    chk("t1_count", count, 4);
    chk("t1_pkt_cnt", pkt_cnt, 1);
    chk("t1_pkt_rdy", pkt_rdy, 1);
    chk("t1_front_typ", front_typ, 2'b11);

    // 2: fill and overflow
    step(1, 0, mk(TYP_HEAD, 5), 0);
    step(1, 0, mk(TYP_BODY, 6), 0);
    step(1, 0, mk(TYP_TAIL, 7), 0);
    step(1, 0, mk(TYP_HEAD, 8), 0);
    chk("t2_full", full, 1);
    chk("t2_pkt_cnt", pkt_cnt, 2);
    step(1, 0, mk(TYP_BODY, 99), 0);
    chk("t2_err_ovf", err_ovf, 1);
    chk("t2_err_typ_quiet", err_typ, 0);
    chk("t2_count", count, 8);
    step(0, 0, '0, 0);
    chk("t2_err_ovf_pulse", err_ovf, 0);

    // 3: simultaneous read and write while full
    step(1, 1, mk(TYP_TAIL, 9), 0);
    chk("t3_count", count, 8);
    chk("t3_full", full, 1);
    chk("t3_out_vld", out_vld, 1);
    chk("t3_pkt_cnt", pkt_cnt, 3);
    for (int i = 0; i < 8; i++) step(0, 1, '0, 0);
    chk("t3_drained", count, 0);
    chk("t3_pkt_cnt_end", pkt_cnt, 0);
    step(0, 0, '0, 0);
    chk("t3_hold_vld", out_vld, 0);
    chk("t3_hold_flit", flit_out, mk(TYP_TAIL, 9));

    // 4: underflow
    step(0, 1, '0, 0);
    chk("t4_err_udf", err_udf, 1);
    chk("t4_out_vld", out_vld, 0);
    chk("t4_count", count, 0);
    chk("t4_empty", empty, 1);

    // 5: streaming across the pointer wrap
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) step(1, k != 0, mk(T5[k], 20 + k), 0);
      else        step(0, 1, '0, 0);
      chk("t5_pkt_cnt", pkt_cnt, 64'(P5[k]));
      chk("t5_count", count, (k < 10) ? 1 : 0);
    end

    // 6: invalid type, then reset with data stored
    step(1, 0, mk(TYP_NONE, 40), 0);
    chk("t6_err_typ", err_typ, 1);
    chk("t6_err_ovf", err_ovf, 0);
    chk("t6_count", count, 0);
    for (int i = 0; i < 5; i++) step(1, 0, mk(TYP_BODY, 50 + i), 0);
    chk("t6_count5", count, 5);
    step(0, 0, '0, 1);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_out_vld", out_vld, 0);
    chk("t6_rst_pkt", pkt_cnt, 0);
    step(0, 1, '0, 0);
    chk("t6_post_udf", err_udf, 1);
    chk("t6_post_vld", out_vld, 0);

    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
